// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
//   Shared types and helpers for the multi-domain reset sequencer.
//   - rst_seq_state_t : sequencer FSM states
//   - thr()           : release threshold for a channel index
// -----------------------------------------------------------------------------
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ASSERT  = 2'd0,
      RELEASE = 2'd1,
      DONE    = 2'd2,
      HOLD    = 2'd3
   } rst_seq_state_t;

   // Edge count after RELEASE entry at which channel i deasserts.
   function automatic int unsigned thr(input int unsigned i,
                                       input int unsigned base,
                                       input int unsigned step);
      return base + (i * step);
   endfunction

endpackage

// File: rtl/rst_sync.sv
// -----------------------------------------------------------------------------
// rst_sync
//   Reset synchroniser: asserts asynchronously, deasserts DEPTH rising edges
//   after rst_n rises.
// Ports:
//   clk    in  system clock
//   rst_n  in  async active-low reset
//   rst_s  out synchronised active-low reset (1 = released)
// -----------------------------------------------------------------------------
module rst_sync #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   output logic rst_s
);

   logic [DEPTH-1:0] sync_r;

   // Shift a constant 1 through the chain once reset is released.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_r <= '0;
      end else begin
         sync_r <= {sync_r[DEPTH-2:0], 1'b1};
      end
   end

   assign rst_s = sync_r[DEPTH-1];

endmodule

// File: rtl/rst_seq.sv
// -----------------------------------------------------------------------------
// rst_seq
//   Parametrised multi-domain reset sequencer. Synchronises the release of
//   the board reset, then deasserts NCH active-high resets in staggered order
//   (channel i at BASE_DLY + i*STEP_DLY edges after RELEASE entry). A
//   sw_rst_req pulse re-asserts every channel, holds them for HOLD_CYC edges
//   and re-runs the release sequence.
// Ports:
//   clk         in   system clock
//   rst_n       in   async active-low reset (asserts async, release synchronised)
//   sw_rst_req  in   1-cycle software reset request
//   rst_out     out  [NCH-1:0] active-high resets, bit i = channel i
//   seq_done    out  1 when every rst_out bit is 0
//   busy        out  1 while in HOLD or RELEASE
// Configuration:
//   RST_SEQ_DISPLAY_EN : simulation messages on each channel release and on
//                        sequence completion; logic is unchanged.
// -----------------------------------------------------------------------------
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int unsigned NCH         = 4,
   parameter int unsigned DLY_W       = 8,
   parameter int unsigned BASE_DLY    = 10,
   parameter int unsigned STEP_DLY    = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYC    = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sw_rst_req,
   output logic [NCH-1:0] rst_out,
   output logic           seq_done,
   output logic           busy
);

   localparam int unsigned      THR_LAST_I = thr(NCH - 32'd1, BASE_DLY, STEP_DLY);
   localparam logic [DLY_W-1:0] THR_LAST   = DLY_W'(THR_LAST_I);
   localparam logic [DLY_W-1:0] HOLD_LIM   = DLY_W'(HOLD_CYC);
   localparam longint unsigned  CNT_MAX    = (64'd1 << DLY_W) - 64'd1;

   // Reject configurations whose thresholds or hold count do not fit the counter.
   if ((64'(THR_LAST_I) > CNT_MAX) || (64'(HOLD_CYC) > CNT_MAX) ||
       (NCH < 32'd1) || (NCH > 32'd16) || (BASE_DLY < 32'd1) ||
       (SYNC_STAGES < 32'd2) || (HOLD_CYC < 32'd1)) begin : g_param_err
      $error("rst_seq: illegal parameter set (NCH=%0d DLY_W=%0d last threshold=%0d)",
             NCH, DLY_W, THR_LAST_I);
   end

   logic                 rst_s;
   rst_seq_state_t       state_r;
   rst_seq_state_t       state_nxt_s;
   logic [DLY_W-1:0]     cnt_r;
   logic [DLY_W-1:0]     cnt_nxt_s;
   logic [NCH-1:0]       rel_s;
   logic [NCH-1:0]       rst_out_r;
   logic [NCH-1:0]       rst_out_nxt_s;
   logic                 seq_done_r;
   logic                 seq_done_nxt_s;
   logic                 busy_r;
   logic                 busy_nxt_s;

   rst_sync #(
      .DEPTH (SYNC_STAGES)
   ) u_rst_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .rst_s (rst_s)
   );

   // Per-channel release flag: evaluated on the next count so the registered
   // output falls on the very edge where the count reaches the threshold.
   for (genvar i = 0; i < NCH; i++) begin : g_thr
      localparam logic [DLY_W-1:0] THR_I = DLY_W'(thr(unsigned'(i), BASE_DLY, STEP_DLY));
      assign rel_s[i] = (cnt_nxt_s >= THR_I);
   end

   // Next-state and counter logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         ASSERT: begin
            cnt_nxt_s = '0;
            if (rst_s) begin
               state_nxt_s = RELEASE;
            end else begin
               state_nxt_s = ASSERT;
            end
         end
         RELEASE: begin
            if (sw_rst_req) begin
               state_nxt_s = HOLD;
               cnt_nxt_s   = '0;
            end else begin
               // Saturate at the last threshold.
               if (cnt_r < THR_LAST) begin
                  cnt_nxt_s = cnt_r + DLY_W'(1);
               end else begin
                  cnt_nxt_s = cnt_r;
               end
               if (cnt_nxt_s == THR_LAST) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = RELEASE;
               end
            end
         end
         DONE: begin
            if (sw_rst_req) begin
               state_nxt_s = HOLD;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = DONE;
            end
         end
         HOLD: begin
            if (sw_rst_req) begin
               // A fresh request restarts the hold window.
               state_nxt_s = HOLD;
               cnt_nxt_s   = '0;
            end else if ((cnt_r + DLY_W'(1)) == HOLD_LIM) begin
               state_nxt_s = RELEASE;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = HOLD;
               cnt_nxt_s   = cnt_r + DLY_W'(1);
            end
         end
         default: begin
            state_nxt_s = ASSERT;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   // Output values as a function of the state being entered.
   always_comb begin
      rst_out_nxt_s  = '1;
      seq_done_nxt_s = 1'b0;
      busy_nxt_s     = 1'b0;
      case (state_nxt_s)
         RELEASE: begin
            rst_out_nxt_s = ~rel_s;
            busy_nxt_s    = 1'b1;
         end
         DONE: begin
            rst_out_nxt_s  = ~rel_s;
            seq_done_nxt_s = 1'b1;
         end
         HOLD: begin
            busy_nxt_s = 1'b1;
         end
         ASSERT: begin
            rst_out_nxt_s = '1;
         end
         default: begin
            rst_out_nxt_s = '1;
         end
      endcase
   end

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ASSERT;
         cnt_r      <= '0;
         rst_out_r  <= '1;
         seq_done_r <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         cnt_r      <= cnt_nxt_s;
         rst_out_r  <= rst_out_nxt_s;
         seq_done_r <= seq_done_nxt_s;
         busy_r     <= busy_nxt_s;
      end
   end

   assign rst_out  = rst_out_r;
   assign seq_done = seq_done_r;
   assign busy     = busy_r;

`ifdef RST_SEQ_DISPLAY_EN
   for (genvar i = 0; i < NCH; i++) begin : g_disp
      // Report each channel release.
      always @(posedge clk) begin
         if (rst_n && rst_out_r[i] && !rst_out_nxt_s[i]) begin
            $display("%0t, Deasserting reset ch %0d", $time, i);
         end
      end
   end

   // Report sequence completion.
   always @(posedge clk) begin
      if (rst_n && (state_r != DONE) && (state_nxt_s == DONE)) begin
         $display("%0t, Reset sequence done", $time);
      end
   end
`else
`endif

endmodule
